// File: rtl/wdt_service_sequencer.sv
// -----------------------------------------------------------------------------
// wdt_service_sequencer
//
// Host-side controller for the watchdog_top ABUS/DBUS register interface.
// On START it unlocks the watchdog (16'hAAAA held UNLOCK_HOLD cycles, then
// 16'h5555), writes the frame-window, service-window and reset-limit
// registers, then services the watchdog at the centre of every service
// window. A reported failure (WDFAIL or RSTOUT) parks the FSM in FAULT until
// firmware relaunches it with another START.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-low reset
//   START       one-cycle launch pulse (honoured in IDLE, CFG_ERR, FAULT)
//   STOP        level; leaves RUN back to IDLE
//   CFG_FW      frame window length, sampled on START
//   CFG_SW      service window length, sampled on START
//   CFG_RL      reset limit, sampled on START
//   WDFAIL      watchdog failure flag
//   RSTOUT      watchdog reset output
//   ABUS        register address to the watchdog
//   DBUS        register data to the watchdog
//   BUSY        high outside IDLE / CFG_ERR / FAULT
//   CONFIGURED  high while in RUN
//   FAULT       high in FAULT
//   CFG_ERR_O   high in CFG_ERR
//   SVC_CNT     services issued since the last START, saturating
// -----------------------------------------------------------------------------
module wdt_service_sequencer #(
    parameter int unsigned UNLOCK_HOLD = 3,
    parameter logic [15:0] SVC_KEY     = 16'h0000,
    parameter logic [2:0]  IDLE_ABUS   = 3'b111
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        STOP,
    input  logic [15:0] CFG_FW,
    input  logic [15:0] CFG_SW,
    input  logic [15:0] CFG_RL,
    input  logic        WDFAIL,
    input  logic        RSTOUT,
    output logic [2:0]  ABUS,
    output logic [15:0] DBUS,
    output logic        BUSY,
    output logic        CONFIGURED,
    output logic        FAULT,
    output logic        CFG_ERR_O,
    output logic [7:0]  SVC_CNT
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_ERR,
        S_UNLOCK_A,
        S_UNLOCK_B,
        S_WR_FW,
        S_WR_SW,
        S_WR_RL,
        S_WR_PAD,
        S_RUN,
        S_SERVICE,
        S_FAULT
    } state_t;

    localparam logic [2:0] ADDR_FW  = 3'b000;  // also the unlock address
    localparam logic [2:0] ADDR_SW  = 3'b001;
    localparam logic [2:0] ADDR_SVC = 3'b010;  // also the pad write
    localparam logic [2:0] ADDR_RL  = 3'b011;

    localparam logic [3:0] HOLD_LAST = 4'(UNLOCK_HOLD - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  hold_cnt;
    logic [15:0] frame_cnt;
    logic [15:0] cfg_fw_q;
    logic [15:0] cfg_sw_q;
    logic [15:0] cfg_rl_q;
    logic [15:0] svc_thr;
    logic        start_accept;
    logic        cfg_valid;
    logic        wd_fail;
    logic        svc_due;

    logic [2:0]  abus_d;
    logic [15:0] dbus_d;
    logic        busy_d;
    logic        configured_d;
    logic        fault_d;
    logic        cfg_err_d;

    assign start_accept = START && (state == S_IDLE || state == S_CFG_ERR || state == S_FAULT);
    assign cfg_valid    = (CFG_FW >= 16'd2) && (CFG_SW != 16'd0) && (CFG_SW <= CFG_FW);
    assign wd_fail      = WDFAIL || RSTOUT;

    // Service lands at the centre of the service window. Validation keeps
    // SW <= FW and FW >= 2, so this never underflows.
    assign svc_thr = cfg_fw_q - 16'd1 - (cfg_sw_q >> 1);
    assign svc_due = (frame_cnt == svc_thr);

    // ---------------------------------------------------------------- state register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------------------------------------------------------- next state
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_CFG_ERR, S_FAULT: begin
                if (START) begin
                    next_state = cfg_valid ? S_UNLOCK_A : S_CFG_ERR;
                end
            end
            S_UNLOCK_A: if (hold_cnt == HOLD_LAST) next_state = S_UNLOCK_B;
            S_UNLOCK_B: next_state = S_WR_FW;
            S_WR_FW:    next_state = S_WR_SW;
            S_WR_SW:    next_state = S_WR_RL;
            S_WR_RL:    next_state = S_WR_PAD;
            S_WR_PAD:   next_state = S_RUN;
            S_RUN: begin
                // Failure beats STOP, and STOP beats a service due this cycle.
                if (wd_fail) begin
                    next_state = S_FAULT;
                end else if (STOP) begin
                    next_state = S_IDLE;
                end else if (svc_due) begin
                    next_state = S_SERVICE;
                end
            end
            S_SERVICE: begin
                // A threshold of 0 (period of one cycle) keeps servicing back to back.
                if (wd_fail) begin
                    next_state = S_FAULT;
                end else if (svc_due) begin
                    next_state = S_SERVICE;
                end else begin
                    next_state = S_RUN;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_cnt  <= '0;
            frame_cnt <= '0;
            cfg_fw_q  <= '0;
            cfg_sw_q  <= '0;
            cfg_rl_q  <= '0;
            SVC_CNT   <= '0;
        end else begin
            hold_cnt <= (state == S_UNLOCK_A) ? hold_cnt + 4'd1 : 4'd0;

            // The SERVICE cycle itself counts as frame cycle 0, so the
            // service-to-service period is FW-(SW>>1) cycles.
            if (state == S_WR_PAD || next_state == S_SERVICE) begin
                frame_cnt <= '0;
            end else if (state == S_RUN || state == S_SERVICE) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            if (start_accept) begin
                cfg_fw_q <= CFG_FW;
                cfg_sw_q <= CFG_SW;
                cfg_rl_q <= CFG_RL;
                SVC_CNT  <= '0;
            end else if (next_state == S_SERVICE && SVC_CNT != 8'hFF) begin
                SVC_CNT <= SVC_CNT + 8'd1;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    // Decoded from next_state and registered, so the bus value for a state
    // is on the pins during the cycle the FSM occupies that state.
    always_comb begin
        abus_d       = IDLE_ABUS;
        dbus_d       = 16'h0000;
        busy_d       = 1'b1;
        configured_d = 1'b0;
        fault_d      = 1'b0;
        cfg_err_d    = 1'b0;
        case (next_state)
            S_IDLE:     busy_d = 1'b0;
            S_CFG_ERR:  begin busy_d = 1'b0; cfg_err_d = 1'b1; end
            S_FAULT:    begin busy_d = 1'b0; fault_d   = 1'b1; end
            S_UNLOCK_A: begin abus_d = ADDR_FW;  dbus_d = 16'hAAAA; end
            S_UNLOCK_B: begin abus_d = ADDR_FW;  dbus_d = 16'h5555; end
            S_WR_FW:    begin abus_d = ADDR_FW;  dbus_d = cfg_fw_q; end
            S_WR_SW:    begin abus_d = ADDR_SW;  dbus_d = cfg_sw_q; end
            S_WR_RL:    begin abus_d = ADDR_RL;  dbus_d = cfg_rl_q; end
            S_WR_PAD:   begin abus_d = ADDR_SVC; dbus_d = 16'h0000; end
            S_RUN:      configured_d = 1'b1;
            S_SERVICE:  begin abus_d = ADDR_SVC; dbus_d = SVC_KEY; configured_d = 1'b1; end
            default:    busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ABUS       <= IDLE_ABUS;
            DBUS       <= 16'h0000;
            BUSY       <= 1'b0;
            CONFIGURED <= 1'b0;
            FAULT      <= 1'b0;
            CFG_ERR_O  <= 1'b0;
        end else begin
            ABUS       <= abus_d;
            DBUS       <= dbus_d;
            BUSY       <= busy_d;
            CONFIGURED <= configured_d;
            FAULT      <= fault_d;
            CFG_ERR_O  <= cfg_err_d;
        end
    end

endmodule
